// File: rtl/rw_mem_pkg.sv
// Shared widths and word/address types for the read/write memory port.
package rw_mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/inf.sv
// Signal bundle between a bench and rw_mem_port; the clocking block keeps
// bench-side drives and samples clear of the active clock edge.
interface inf
    import rw_mem_pkg::*;
(
    input logic clk
);
    logic  read;
    logic  write;
    logic  enable;
    addr_t raddr;
    addr_t waddr;
    data_t wdata;
    data_t rdata;

    clocking cb @(posedge clk);
        output read, write, enable, raddr, waddr, wdata;
        input  rdata;
    endclocking

    modport dut (input clk, read, write, enable, raddr, waddr, wdata, output rdata);
    modport tb  (input clk, rdata, output read, write, enable, raddr, waddr, wdata, clocking cb);
endinterface

// File: rtl/rw_mem_array.sv
// 2**ADDR_W x DATA_W storage with an identity reset image, one write port and a
// registered read-first read port.
module rw_mem_array
    import rw_mem_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // Read samples mem_q, so a same-address write in this cycle is not seen yet.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(i);
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/rw_mem_port.sv
// Enable-gated wrapper around rw_mem_array; rvalid marks the cycle after an
// accepted read.
module rw_mem_port
    import rw_mem_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W,
    parameter int DEPTH = 2 ** AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] raddr,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);
    logic re, we;
    logic rvalid_q, rvalid_d;

    assign re = enable & read;
    assign we = enable & write;

    always_comb begin
        rvalid_d = re;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid_q <= 1'b0;
        else     rvalid_q <= rvalid_d;
    end

    assign rvalid = rvalid_q;

    rw_mem_array #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_rw_mem_port.sv
// Directed bench for rw_mem_port: inputs change on the falling edge, outputs
// are checked on the falling edge after each rising edge.
module tb_rw_mem_port;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable, read, write;
    logic [7:0] raddr, waddr, wdata;
    logic [7:0] rdata;
    logic       rvalid;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    rw_mem_port dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .read   (read),
        .write  (write),
        .raddr  (raddr),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    task automatic chk(input string tag, input logic [7:0] d_exp, input logic v_exp);
        n_cmp++;
        assert (rdata === d_exp) else begin
            n_err++;
            $error("FAIL %s rdata: got %h want %h", tag, rdata, d_exp);
        end
        n_cmp++;
        assert (rvalid === v_exp) else begin
            n_err++;
            $error("FAIL %s rvalid: got %b want %b", tag, rvalid, v_exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic en, input logic rd, input logic [7:0] ra,
                       input logic wr, input logic [7:0] wa, input logic [7:0] wd);
        enable = en; read = rd; raddr = ra; write = wr; waddr = wa; wdata = wd;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        cyc();
        chk("reset_held", 8'h00, 1'b0);
        rst = 1'b0;

        drv(1, 1, 8'd4, 0, 0, 0);     cyc(); chk("read4", 8'd4, 1'b1);
        drv(1, 0, 0, 0, 0, 0);        cyc(); chk("idle_hold", 8'd4, 1'b0);

        drv(1, 0, 0, 1, 8'd5, 8'd22); cyc(); chk("write5_no_rvalid", 8'd4, 1'b0);
        drv(1, 1, 8'd5, 0, 0, 0);     cyc(); chk("read5_new", 8'd22, 1'b1);
        drv(1, 1, 8'd4, 0, 0, 0);     cyc(); chk("read4_untouched", 8'd4, 1'b1);

        drv(0, 1, 8'd5, 1, 8'd6, 8'hAA); cyc(); chk("disabled_hold", 8'd4, 1'b0);
        drv(1, 1, 8'd6, 0, 0, 0);     cyc(); chk("read6_write_ignored", 8'd6, 1'b1);

        drv(1, 1, 8'd9, 1, 8'd9, 8'h55); cyc(); chk("rw_same_read_first", 8'd9, 1'b1);
        drv(1, 1, 8'd9, 0, 0, 0);     cyc(); chk("read9_after", 8'h55, 1'b1);

        drv(1, 0, 0, 1, 8'd255, 8'h3C); cyc(); chk("write255", 8'h55, 1'b0);
        drv(1, 1, 8'd255, 0, 0, 0);   cyc(); chk("read255", 8'h3C, 1'b1);
        drv(1, 1, 8'd0, 0, 0, 0);     cyc(); chk("read0", 8'h00, 1'b1);

        drv(1, 1, 8'd5, 0, 0, 0);     cyc(); chk("read5_pre_rst", 8'd22, 1'b1);
        // Asynchronous reset between edges with a read still requested.
        #2 rst = 1'b1;
        #1 chk("async_rst", 8'h00, 1'b0);
        cyc(); chk("rst_held_read", 8'h00, 1'b0);
        rst = 1'b0;
        drv(1, 1, 8'd5, 0, 0, 0);     cyc(); chk("read5_after_rst", 8'd5, 1'b1);
        drv(1, 1, 8'd255, 0, 0, 0);   cyc(); chk("read255_after_rst", 8'd255, 1'b1);
        drv(1, 1, 8'd9, 0, 0, 0);     cyc(); chk("read9_after_rst", 8'd9, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rw_mem_port.md
Name: rw_mem_port

Overview:
- Synchronous 256 x 8 storage block with an independent read port and write port, gated by a common enable.
- Used as the device under test that a testbench drives through a shared signal-bundle interface.
- Reset loads a known identity pattern, so reads give deterministic values before any write.

Parameters:
ADDR_W, 8, address width of both ports
DATA_W, 8, data word width
DEPTH, 2**ADDR_W, number of storage words (256)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
enable  input  1  global port enable; read and write are ignored while low
read  input  1  read request, sampled at rising clk
write  input  1  write request, sampled at rising clk
raddr  input  ADDR_W  read address
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
rdata  output  DATA_W  registered read data
rvalid  output  1  high for the cycle in which rdata was updated by an accepted read

Behaviour:
- Reset:
  - rst high asynchronously forces rdata=0 and rvalid=0.
  - It loads mem[i]=i[DATA_W-1:0] for every i.
  - Reset held across edges keeps these values.
  - Reset asserted mid-operation discards any in-flight access.
  - Writes made before reset are lost.
- Write:
  - At a rising edge with enable=1 and write=1, mem[waddr] <= wdata.
  - One-cycle latency: the new value is visible to a read issued at the next edge.
- Read:
  - At a rising edge with enable=1 and read=1, rdata <= mem[raddr] and rvalid <= 1.
  - rdata is valid immediately after that edge, with 1-cycle latency from request to data.
- Idle:
  - With no accepted read, rdata holds its last value and rvalid <= 0.
- enable=0: read, write, raddr, waddr and wdata are don't-care; memory and rdata hold; rvalid <= 0.
- Simultaneous read and write in the same cycle:
  - Both are performed.
  - If raddr==waddr, read-first applies: rdata returns the old contents and the new value is stored.
- Addresses are full-range with no wrap-around logic required; 255 is a legal address.
- Inputs are sampled only at rising clk; changes between edges have no effect.
- X on read/write while enable=1 is a bench error; no RTL protection is required.

Decomposition:
- Package rw_mem_pkg holds:
  - ADDR_W and DATA_W defaults
  - typedefs addr_t = logic [ADDR_W-1:0] and data_t = logic [DATA_W-1:0]
- Interface inf bundles the signals:
  - It takes clk as its port and carries read, write, enable, raddr, waddr, wdata and rdata.
  - Modport dut: clk, read, write, enable, raddr, waddr and wdata are inputs; rdata is an output.
  - Modport tb mirrors the dut modport.
  - A clocking block at posedge clk drives and samples the tb side, avoiding edge races.
- Sub-module rw_mem_array holds the storage array:
  - reset-init loop
  - write port
  - read-first read register
- rw_mem_port wraps rw_mem_array and adds the enable gating and rvalid.

Test Plan:
- Reset, then enable=1, read=1, raddr=4 for one edge -> after that edge rdata=4, rvalid=1; next idle edge rvalid=0 and rdata stays 4.
- enable=1, write=1, waddr=5, wdata=22; then read raddr=5 -> rdata=22 one edge after the read request; mem[4] is still 4.
- enable=0, write=1, waddr=6, wdata=0xAA; then enable=1 read raddr=6 -> rdata=6 (write ignored), and rvalid stays 0 while enable=0.
- Same edge: write waddr=9, wdata=0x55, plus read raddr=9 -> rdata=9 (old value); a following read of 9 -> 0x55.
- Write addr 255 with 0x3C, then read 255 -> 0x3C; read 0 -> 0.
- After writing 22 to addr 5, assert rst between edges -> rdata=0 and rvalid=0 immediately; after release, read 5 -> 5.
